// File: rtl/line_buffer_window_control.sv
// Window-position controller for a KxK line buffer fed by a row-major pixel stream.
// Strobes output_valid one cycle after each accepted pixel that completes a strided window.
module line_buffer_window_control #(
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             eof,
  input  logic             input_valid,
  output logic             in_ready,
  output logic             output_valid,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic             reset_all_cell,
  output logic             frame_done,
  output logic             err_eof,
  output logic [1:0]       state
);

  if (K < 2 || K > IMG_W || K > IMG_H || STRIDE < 1 || STRIDE > K ||
      IMG_W >= (1 << CNT_W) || IMG_H >= (1 << CNT_W)) begin : g_bad_params
    $error("line_buffer_window_control: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, CLEAR = 2'd3} state_t;

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_R = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] KM1    = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] KM2    = CNT_W'(K - 2);
  localparam logic [CNT_W-1:0] SM1    = CNT_W'(STRIDE - 1);

  state_t st;

  // col/row: coordinate of the next pixel. cph/rph: offset modulo STRIDE past K-1,
  // wc/wr: window index that a hit at the current coordinate would produce.
  logic [CNT_W-1:0] col, row, cph, rph, wc, wr;
  logic [CNT_W-1:0] col_n, row_n, cph_n, rph_n, wc_n, wr_n;
  logic accept, adv, win, last;

  assign in_ready = (st != CLEAR);
  assign state    = st;
  assign accept   = input_valid && in_ready;
  assign adv      = accept && ((st == FILL) || (st == RUN) || ((st == IDLE) && sof));
  assign win      = (col >= KM1) && (row >= KM1) && (cph == '0) && (rph == '0);
  assign last     = (col == LAST_C) && (row == LAST_R);

  always_comb begin
    col_n = col;
    row_n = row;
    cph_n = cph;
    rph_n = rph;
    wc_n  = wc;
    wr_n  = wr;
    if (col == LAST_C) begin
      col_n = '0;
      cph_n = '0;
      wc_n  = '0;
      row_n = (row == LAST_R) ? '0 : row + 1'b1;
      if (row < KM1) begin
        rph_n = '0;
        wr_n  = '0;
      end else if (rph == SM1) begin
        rph_n = '0;
        wr_n  = wr + 1'b1;
      end else begin
        rph_n = rph + 1'b1;
      end
    end else begin
      col_n = col + 1'b1;
      if (col < KM1) begin
        cph_n = '0;
        wc_n  = '0;
      end else if (cph == SM1) begin
        cph_n = '0;
        wc_n  = wc + 1'b1;
      end else begin
        cph_n = cph + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= IDLE;
      col            <= '0;
      row            <= '0;
      cph            <= '0;
      rph            <= '0;
      wc             <= '0;
      wr             <= '0;
      output_valid   <= 1'b0;
      out_row        <= '0;
      out_col        <= '0;
      reset_all_cell <= 1'b0;
      frame_done     <= 1'b0;
      err_eof        <= 1'b0;
    end else begin
      output_valid   <= 1'b0;
      reset_all_cell <= 1'b0;
      frame_done     <= 1'b0;
      err_eof        <= 1'b0;

      if (st == CLEAR) begin
        col <= '0;
        row <= '0;
        cph <= '0;
        rph <= '0;
        wc  <= '0;
        wr  <= '0;
      end else if (adv) begin
        col <= col_n;
        row <= row_n;
        cph <= cph_n;
        rph <= rph_n;
        wc  <= wc_n;
        wr  <= wr_n;
      end

      unique case (st)
        IDLE: begin
          if (adv) begin
            // A one-pixel frame is an early eof like any other.
            if (eof) begin
              st             <= CLEAR;
              err_eof        <= 1'b1;
              reset_all_cell <= 1'b1;
              frame_done     <= 1'b1;
            end else begin
              st <= FILL;
            end
          end
        end
        FILL, RUN: begin
          if (adv) begin
            if (win) begin
              output_valid <= 1'b1;
              out_row      <= wr;
              out_col      <= wc;
            end
            if (last || eof) begin
              st             <= CLEAR;
              err_eof        <= !(last && eof);
              reset_all_cell <= 1'b1;
              frame_done     <= 1'b1;
            end else if ((st == FILL) && (row == KM2) && (col == LAST_C)) begin
              st <= RUN;
            end
          end
        end
        CLEAR: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_window_control.sv
// Directed + randomized bench for line_buffer_window_control against a pixel-index model.
module tb_line_buffer_window_control;
  localparam int W = 6, H = 6, K = 3, S = 1, CW = 11;
  localparam int W2 = 7, H2 = 7, S2 = 2;

  logic clk = 1'b0;
  logic rst, sof, eof, iv;
  logic in_ready, output_valid, reset_all_cell, frame_done, err_eof;
  logic [CW-1:0] out_row, out_col;
  logic [1:0] state;

  logic sof2, eof2, iv2;
  logic in_ready2, output_valid2, reset_all_cell2, frame_done2, err_eof2;
  logic [CW-1:0] out_row2, out_col2;
  logic [1:0] state2;

  always #5 clk = ~clk;

  line_buffer_window_control #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sof(sof), .eof(eof), .input_valid(iv), .in_ready(in_ready),
    .output_valid(output_valid), .out_row(out_row), .out_col(out_col),
    .reset_all_cell(reset_all_cell), .frame_done(frame_done), .err_eof(err_eof), .state(state));

  line_buffer_window_control #(.IMG_W(W2), .IMG_H(H2), .K(K), .STRIDE(S2), .CNT_W(CW)) dut2 (
    .clk(clk), .rst(rst), .sof(sof2), .eof(eof2), .input_valid(iv2), .in_ready(in_ready2),
    .output_valid(output_valid2), .out_row(out_row2), .out_col(out_col2),
    .reset_all_cell(reset_all_cell2), .frame_done(frame_done2), .err_eof(err_eof2), .state(state2));

  int tests = 0, fails = 0;
  bit m_act = 0, m_clr = 0;
  int m_n = 0;
  bit e_ov, e_fd, e_rac, e_err;
  int e_r = 0, e_c = 0;
  int dut_strobes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: a frame is a sequence of accepted pixels numbered 0..W*H-1.
  task automatic step(input bit v, input bit s, input bit e);
    int r, c;
    int exp_state;
    iv = v; sof = s; eof = e;
    e_ov = 0; e_fd = 0; e_rac = 0; e_err = 0;
    if (m_clr) begin
      m_clr = 0;
    end else if (v && (m_act || s)) begin
      if (!m_act) begin m_act = 1; m_n = 0; end
      r = m_n / W; c = m_n % W;
      if (r >= K-1 && c >= K-1 && (r-(K-1)) % S == 0 && (c-(K-1)) % S == 0) begin
        e_ov = 1; e_r = (r-(K-1)) / S; e_c = (c-(K-1)) / S;
      end
      if (m_n == W*H-1 || e) begin
        e_err = !(m_n == W*H-1 && e);
        m_clr = 1; m_act = 0; m_n = 0; e_fd = 1; e_rac = 1;
      end else begin
        m_n++;
      end
    end
    @(posedge clk); #1;
    exp_state = m_clr ? 3 : (!m_act ? 0 : (m_n >= (K-1)*W ? 2 : 1));
    if (output_valid) dut_strobes++;
    chk("output_valid", output_valid, e_ov);
    chk("out_row", out_row, e_r);
    chk("out_col", out_col, e_c);
    chk("frame_done", frame_done, e_fd);
    chk("reset_all_cell", reset_all_cell, e_rac);
    chk("err_eof", err_eof, e_err);
    chk("in_ready", in_ready, !m_clr);
    chk("state", state, exp_state);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ov"}, output_valid, 0);
    chk({tag, "_row"}, out_row, 0);
    chk({tag, "_col"}, out_col, 0);
    chk({tag, "_rac"}, reset_all_cell, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_err"}, err_eof, 0);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_state"}, state, 0);
  endtask

  // Raise rst mid-cycle so only the asynchronous path can clear the outputs.
  task automatic do_reset();
    iv = 0; sof = 0; eof = 0;
    #2 rst = 1;
    #1 check_reset("async_rst");
    m_act = 0; m_clr = 0; m_n = 0; e_r = 0; e_c = 0;
    @(posedge clk); #1 rst = 0;
  endtask

  // mode 0: contiguous, 1: valid toggling, 2: random gaps
  task automatic frame(input int mode);
    for (int p = 0; p < W*H; p++) begin
      if (mode == 1 && p > 0) step(0, 0, 0);
      if (mode == 2) while ($urandom_range(0, 2) == 0) step(0, 0, 0);
      step(1, p == 0, p == W*H-1);
    end
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    int full_cnt, n2, r, c;
    bit x_ov;
    full_cnt = ((H-K)/S+1) * ((W-K)/S+1);
    rst = 1; iv = 0; sof = 0; eof = 0;
    iv2 = 0; sof2 = 0; eof2 = 0;
    #3 check_reset("reset");
    @(posedge clk); #1 rst = 0;

    dut_strobes = 0; frame(0);
    chk("strobes_contig", dut_strobes, full_cnt);
    dut_strobes = 0; frame(1);
    chk("strobes_toggle", dut_strobes, full_cnt);
    dut_strobes = 0; frame(2);
    chk("strobes_random_gaps", dut_strobes, full_cnt);

    // early eof at pixel 20, then pixels without sof are dropped
    for (int p = 0; p <= 20; p++) step(1, p == 0, p == 20);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // reset after pixel 17, then a clean frame
    for (int p = 0; p <= 17; p++) step(1, p == 0, 0);
    do_reset();
    dut_strobes = 0; frame(0);
    chk("strobes_after_rst", dut_strobes, full_cnt);

    // back-to-back: sof offered during CLEAR, then again in IDLE
    for (int p = 0; p < W*H; p++) step(1, p == 0, p == W*H-1);
    step(1, 1, 0);
    dut_strobes = 0;
    step(1, 1, 0);
    for (int p = 1; p < W*H; p++) step(1, 0, p == W*H-1);
    step(0, 0, 0);
    chk("strobes_b2b", dut_strobes, full_cnt);

    // random control traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 12) == 0, $urandom_range(0, 40) == 0);
    step(0, 0, 0); step(0, 0, 0);

    // stride-2 instance on a 7x7 frame
    n2 = 0;
    for (int p = 0; p < W2*H2; p++) begin
      iv2 = 1; sof2 = (p == 0); eof2 = (p == W2*H2-1);
      r = p / W2; c = p % W2;
      x_ov = (r >= K-1 && c >= K-1 && (r-(K-1)) % S2 == 0 && (c-(K-1)) % S2 == 0);
      @(posedge clk); #1;
      chk("s2_ov", output_valid2, x_ov);
      if (x_ov) begin
        n2++;
        chk("s2_row", out_row2, (r-(K-1)) / S2);
        chk("s2_col", out_col2, (c-(K-1)) / S2);
      end
      chk("s2_fd", frame_done2, p == W2*H2-1);
      chk("s2_err", err_eof2, 0);
    end
    iv2 = 0; sof2 = 0; eof2 = 0;
    @(posedge clk); #1;
    chk("s2_strobes", n2, ((H2-K)/S2+1) * ((W2-K)/S2+1));
    chk("s2_idle", state2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
